// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS main control: opcodes, ALUOp codes,
// mux select encodings and the FSM state encoding exported on state_dbg.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SUBI  = 6'd9;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_REXEC   = 4'd7,
    S_RWB     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_SUBIEX  = 4'd10,
    S_IWB     = 4'd11,
    S_BRANCH  = 4'd12,
    S_JUMP    = 4'd13,
    S_ILLEGAL = 4'd14
  } state_e;

  // States that sit on the memory ready handshake and are watched by the timer.
  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_mem_wait_timer.sv
// Saturating wait counter: clear has priority, expire when the count equals
// TIMEOUT_CYCLES; a zero limit never expires.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMR_W          = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback and drives all datapath enables, mux selects and ALUOp.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMR_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_dbg
);

  state_e state_q, state_d;
  logic   tmr_expire, tmr_clr, tmr_en, timeout_fire;
  logic   unused_zero;

  // The branch decision (pc_write_cond & zero) is resolved in the datapath.
  assign unused_zero = zero;

  assign tmr_en       = is_mem_wait(state_q) && !mem_ready;
  assign timeout_fire = tmr_en && tmr_expire;
  assign tmr_clr      = timeout_fire || (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    illegal_op    = 1'b0;
    mem_timeout   = timeout_fire;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        unique case (opcode)
          OP_RTYPE:     state_d = S_REXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_SUBI:      state_d = S_SUBIEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)       state_d = S_MEMWB;
        else if (tmr_expire) state_d = S_FETCH;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready || tmr_expire) state_d = S_FETCH;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX, S_SUBIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (state_q == S_SUBIEX) ? ALUOP_SUB : ALUOP_ADD;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_op = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with a short watchdog limit of 4.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_timeout;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;
  logic [18:0] outs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(4), .TMR_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_dbg(state_dbg)
  );

  assign outs = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
                 ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                 alu_op, illegal_op, mem_timeout};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    #3;
    chk("reset_state", state_dbg, 0);
    chk("reset_outs", outs, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_idle", state_dbg, 0);
    tick();
    chk("idle_to_fetch", state_dbg, 1);

    // R-type, ready tied high: FETCH DECODE REXEC RWB
    mem_ready = 1'b1; opcode = 6'd0;
    #1;
    chk("fetch_ir_write", ir_write, 1);
    chk("fetch_pc_write", pc_write, 1);
    chk("fetch_srcb", alu_src_b, 1);
    tick();
    chk("r_decode", state_dbg, 2);
    chk("decode_srcb", alu_src_b, 3);
    chk("decode_no_ir", ir_write, 0);
    tick();
    chk("r_rexec", state_dbg, 7);
    chk("rexec_aluop", alu_op, 3'b010);
    chk("rexec_no_regw", reg_write, 0);
    tick();
    chk("r_rwb", state_dbg, 8);
    chk("rwb_regw", reg_write, 1);
    chk("rwb_regdst", reg_dst, 1);
    tick();
    chk("r_back_fetch", state_dbg, 1);

    // lw with three not-ready cycles in MEMRD
    opcode = 6'd35;
    tick();
    tick();
    chk("lw_memadr", state_dbg, 3);
    chk("memadr_srca", alu_src_a, 1);
    chk("memadr_srcb", alu_src_b, 2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_memrd_hold", state_dbg, 4);
      chk("memrd_iord", iord, 1);
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_memrd_last", state_dbg, 4);
    chk("memrd_no_timeout", mem_timeout, 0);
    tick();
    chk("lw_memwb", state_dbg, 5);
    chk("memwb_regw", reg_write, 1);
    chk("memwb_m2r", mem_to_reg, 1);
    chk("memwb_regdst", reg_dst, 0);
    tick();
    chk("lw_back_fetch", state_dbg, 1);

    // beq, zero high then low: control outputs ignore zero
    opcode = 6'd4; zero = 1'b1;
    tick();
    tick();
    chk("beq_state", state_dbg, 12);
    chk("beq_aluop", alu_op, 3'b001);
    chk("beq_pcwc", pc_write_cond, 1);
    chk("beq_pcsrc", pc_source, 1);
    chk("beq_no_pcw", pc_write, 0);
    tick();
    chk("beq_back_fetch", state_dbg, 1);
    zero = 1'b0;
    tick();
    tick();
    chk("beq_z0_pcwc", pc_write_cond, 1);
    tick();

    // subi then addi
    opcode = 6'd9;
    tick();
    tick();
    chk("subi_state", state_dbg, 10);
    chk("subi_aluop", alu_op, 3'b001);
    tick();
    chk("iwb_state", state_dbg, 11);
    chk("iwb_regw", reg_write, 1);
    chk("iwb_regdst", reg_dst, 0);
    tick();
    opcode = 6'd8;
    tick();
    tick();
    chk("addi_state", state_dbg, 9);
    chk("addi_aluop", alu_op, 3'b000);
    chk("addi_srcb", alu_src_b, 2);
    tick();
    tick();

    // jump
    opcode = 6'd2;
    tick();
    tick();
    chk("j_state", state_dbg, 13);
    chk("j_pcw", pc_write, 1);
    chk("j_pcsrc", pc_source, 2);
    tick();
    chk("j_back_fetch", state_dbg, 1);

    // undecoded opcode
    opcode = 6'd63;
    tick();
    tick();
    chk("ill_state", state_dbg, 14);
    chk("ill_pulse", illegal_op, 1);
    chk("ill_no_regw", reg_write, 0);
    chk("ill_no_memw", mem_write, 0);
    chk("ill_no_pcw", pc_write, 0);
    tick();
    chk("ill_back_fetch", state_dbg, 1);
    chk("ill_pulse_end", illegal_op, 0);

    // sw timing out in MEMWR
    opcode = 6'd43;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    chk("sw_memwr", state_dbg, 6);
    chk("sw_memw", mem_write, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sw_wait_no_to", mem_timeout, 0);
    end
    tick();
    chk("sw_expire_state", state_dbg, 6);
    chk("sw_timeout", mem_timeout, 1);
    tick();
    chk("sw_to_fetch", state_dbg, 1);
    chk("to_pulse_end", mem_timeout, 0);
    chk("to_no_irw", ir_write, 0);

    // FETCH timeout re-enters FETCH
    for (int i = 0; i < 3; i++) tick();
    chk("fetch_wait_no_to", mem_timeout, 0);
    tick();
    chk("fetch_timeout", mem_timeout, 1);
    chk("fetch_to_no_pcw", pc_write, 0);
    tick();
    chk("fetch_reenter", state_dbg, 1);
    chk("fetch_to_cleared", mem_timeout, 0);

    // sw with ready arriving on the expiry cycle
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) tick();
    mem_ready = 1'b1;
    #1;
    chk("race_state", state_dbg, 6);
    chk("race_no_timeout", mem_timeout, 0);
    tick();
    chk("race_to_fetch", state_dbg, 1);

    // reset asserted mid-MEMWR
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    chk("rst_pre_memw", mem_write, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_memw", mem_write, 0);
    chk("rst_async_state", state_dbg, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_rel_idle", state_dbg, 0);
    tick();
    chk("rst_rel_fetch", state_dbg, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
